// File: rtl/uart_xcvr_param.sv
// uart_xcvr_param: parametrised UART transceiver with TX/RX FIFOs; even parity when UART_PARITY_EN is defined
module uart_xcvr_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic                 tx_wr,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_full,
  output logic                 tx_busy,
  input  logic                 rx_rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] TOP  = IW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef UART_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  function automatic logic full_f(input logic [AW:0] w, input logic [AW:0] r);
    return (w ^ r) == {1'b1, {AW{1'b0}}};
  endfunction
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wp, tx_rp, tx_wp_n, tx_rp_n;
  logic                 tx_ne, tx_pop, tx_push, tx_tick;
  logic [DATA_BITS-1:0] tx_head, tx_sh;
  state_t               tx_st;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif
  assign tx_ne   = tx_wp != tx_rp;
  assign tx_tick = tx_cnt == LAST;
  assign tx_head = tx_mem[tx_rp[AW-1:0]];
  assign tx_pop  = tx_ne && (tx_st == IDLE || (tx_st == STOP && tx_tick));
  assign tx_push = tx_wr && (!tx_full || tx_pop);
  assign tx_wp_n = tx_wp + {{AW{1'b0}}, tx_push};
  assign tx_rp_n = tx_rp + {{AW{1'b0}}, tx_pop};
  assign tx_busy = tx_st != IDLE || tx_ne;
  // TX FIFO pointers and registered full flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_wp   <= '0;
      tx_rp   <= '0;
      tx_full <= 1'b0;
    end else begin
      tx_wp   <= tx_wp_n;
      tx_rp   <= tx_rp_n;
      tx_full <= full_f(tx_wp_n, tx_rp_n);
    end
  // TX FIFO storage
  always_ff @(posedge clk)
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= tx_data;
  // TX framing FSM; a pending word at the end of STOP starts the next frame with no gap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_st   <= IDLE;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_sh   <= '0;
      uart_tx <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par  <= 1'b0;
`endif
    end else begin
      tx_cnt <= (tx_st == IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      if (tx_pop) begin
        tx_st   <= START;
        tx_sh   <= tx_head;
        uart_tx <= 1'b0;
`ifdef UART_PARITY_EN
        tx_par  <= ^tx_head;
`endif
      end else if (tx_tick)
        case (tx_st)
          START: begin
            tx_st   <= DATA;
            tx_idx  <= '0;
            uart_tx <= tx_sh[0];
          end
          DATA:
            if (tx_idx == TOP) begin
              tx_st <= AFTER_DATA;
`ifdef UART_PARITY_EN
              uart_tx <= tx_par;
`else
              uart_tx <= 1'b1;
`endif
            end else begin
              tx_idx  <= tx_idx + 1'b1;
              tx_sh   <= tx_sh >> 1;
              uart_tx <= tx_sh[1];
            end
          PARITY: begin
            tx_st   <= STOP;
            uart_tx <= 1'b1;
          end
          STOP: begin
            tx_st   <= IDLE;
            uart_tx <= 1'b1;
          end
          default: tx_st <= IDLE;
        endcase
    end
  logic                 rx_s1, rx_s2, rx_s3;
  state_t               rx_st;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_samp, rx_push, rx_perr, rx_full, rx_pop, rx_wr;
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wp, rx_rp, rx_wp_n, rx_rp_n;
  assign rx_samp = (rx_st == START) ? rx_cnt == HALF : rx_cnt == LAST;
  assign rx_push = rx_st == STOP && rx_samp && rx_s2 && !rx_perr;
`ifndef UART_PARITY_EN
  assign rx_perr = 1'b0;
`endif
  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) {rx_s3, rx_s2, rx_s1} <= 3'b111;
    else {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, uart_rx};
  // RX FSM; returns to IDLE at the stop sample so a close following start bit is caught
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_st        <= IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_sh        <= '0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr      <= 1'b0;
`endif
    end else begin
      rx_frame_err <= 1'b0;
      rx_cnt <= (rx_st == IDLE || rx_samp) ? '0 : rx_cnt + 1'b1;
      case (rx_st)
        IDLE:
          if (rx_s3 && !rx_s2) rx_st <= START;
        START:
          if (rx_samp) begin
            rx_st  <= rx_s2 ? IDLE : DATA;
            rx_idx <= '0;
          end
        DATA:
          if (rx_samp) begin
            rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
            rx_idx <= rx_idx + 1'b1;
            if (rx_idx == TOP) rx_st <= AFTER_DATA;
          end
        PARITY:
          if (rx_samp) begin
            rx_st <= STOP;
`ifdef UART_PARITY_EN
            rx_perr <= rx_s2 ^ (^rx_sh);
`endif
          end
        STOP:
          if (rx_samp) begin
            rx_st        <= IDLE;
            rx_frame_err <= !rx_s2 || rx_perr;
          end
        default: rx_st <= IDLE;
      endcase
    end
  assign rx_pop  = rx_rd && !rx_empty;
  assign rx_full = full_f(rx_wp, rx_rp);
  assign rx_wr   = rx_push && (!rx_full || rx_pop);
  assign rx_wp_n = rx_wp + {{AW{1'b0}}, rx_wr};
  assign rx_rp_n = rx_rp + {{AW{1'b0}}, rx_pop};
  assign rx_data = rx_mem[rx_rp[AW-1:0]];
  // RX FIFO; storage is cleared so the show-ahead head reads zero after reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_empty   <= 1'b1;
      rx_overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
    end else begin
      rx_wp    <= rx_wp_n;
      rx_rp    <= rx_rp_n;
      rx_empty <= rx_wp_n == rx_rp_n;
      if (rx_push && !rx_wr) rx_overrun <= 1'b1;
      if (rx_wr) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end
endmodule

// File: doc/uart_xcvr_param.md
# uart_xcvr_param

Parametrised UART transceiver for the optical link front end. It replaces the fixed 8-bit, single-register transceiver with configurable data width, baud divisor and independent TX/RX FIFOs, and adds framing and overrun error reporting. It sits between the host-side byte interface and the serial line that drives the optical emitter and receiver.

## Interface
- DATA_BITS, 8: payload bits per frame; legal range 5–9.
- CLKS_PER_BIT, 868: clk cycles per serial bit (100 MHz / 115200); minimum 8.
- FIFO_DEPTH, 8: entries per FIFO; must be a power of two, 2–64.

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- uart_rx  in  1  serial input, asynchronous to clk; idle high.
- uart_tx  out  1  serial output; idle high.
- tx_wr  in  1  one-cycle strobe that pushes tx_data into the TX FIFO.
- tx_data  in  DATA_BITS  word to transmit.
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  high while a frame is on the line or the TX FIFO is non-empty.
- rx_rd  in  1  one-cycle strobe that pops the RX FIFO head.
- rx_data  out  DATA_BITS  RX FIFO head (show-ahead); valid while rx_empty=0.
- rx_empty  out  1  RX FIFO empty.
- rx_frame_err  out  1  one-cycle pulse when a bad stop bit (or parity error) is detected.
- rx_overrun  out  1  sticky flag; a received word was dropped because the RX FIFO was full.

## Operation
- Reset values: uart_tx=1, tx_full=0, tx_busy=0, rx_data=0, rx_empty=1, rx_frame_err=0, rx_overrun=0. Both FIFOs are emptied and both FSMs return to IDLE. Reset asserted mid-frame aborts the frame immediately; no partial word is stored.
- Frame format: start bit (0), then DATA_BITS data bits LSB first, then an optional parity bit, then one stop bit (1).
- TX FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - Leaves IDLE when the TX FIFO is non-empty; the word is popped on entry to START.
  - Each state lasts exactly CLKS_PER_BIT cycles.
  - If the FIFO is non-empty at the end of STOP, the FSM goes directly to START with no idle gap.
- TX FIFO: tx_wr while tx_full=1 is ignored and the FIFO is unchanged. tx_wr on the same cycle as an internal pop is accepted even when the FIFO is full.
- RX path:
  - uart_rx passes through a 2-flop synchroniser.
  - RX FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - A falling edge on the synchronised input in IDLE enters START. At CLKS_PER_BIT/2 (integer division) the line is re-sampled; if it is high, the start is treated as a glitch and the FSM returns to IDLE.
  - Each subsequent bit is sampled at its centre, CLKS_PER_BIT after the previous sample.
  - At the STOP sample:
    - Line=1 and no parity error: the word is pushed to the RX FIFO.
    - Otherwise: the word is discarded and rx_frame_err pulses for 1 cycle.
  - The FSM returns to IDLE at the stop-bit sample point, not at the end of the stop bit, so it can resynchronise on a closely following start bit.
- RX FIFO:
  - Push while full drops the word and sets rx_overrun, which stays set until rst.
  - rx_rd while rx_empty=1 is ignored.
  - A push and a pop on the same cycle while full are both performed.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide, with the extra MSB used for full/empty disambiguation. The baud counter is $clog2(CLKS_PER_BIT) bits wide and wraps at CLKS_PER_BIT-1.

## Timing
- tx_wr to uart_tx falling edge: 2 cycles when idle (1 cycle FIFO write, 1 cycle pop/START, registered output).
- uart_tx is registered and glitch-free.
- A frame occupies (DATA_BITS + 2 + P) × CLKS_PER_BIT cycles, where P=1 when parity is enabled and 0 otherwise.
- RX word visibility: rx_empty deasserts 1 cycle after the stop-bit sample. The stop-bit sample occurs about 2 + (DATA_BITS + 1.5 + P) × CLKS_PER_BIT cycles after the start edge arrives on the pin.
- rx_data updates 1 cycle after rx_rd.
- tx_full and rx_empty are registered and reflect the FIFO state after the current cycle's operations.

## Configuration
- UART_PARITY_EN defined:
  - A PARITY state is inserted in both FSMs.
  - TX sends even parity over the data bits.
  - RX checks the parity bit; a mismatch causes the word to be discarded with an rx_frame_err pulse at the stop-bit sample.
- UART_PARITY_EN undefined: no parity bit is sent or expected, and parity logic is absent.

## Test plan
- Loopback (uart_tx tied to uart_rx), CLKS_PER_BIT=16, DATA_BITS=8: write 0xB2 then 0xAA → rx_data=0xB2, then 0xAA after rx_rd; rx_frame_err stays 0.
- Back-to-back TX: write 4 words in 4 consecutive cycles → uart_tx shows 4 frames with no idle gap; tx_busy falls exactly after the 4th stop bit.
- Overrun, FIFO_DEPTH=4: send 5 frames with no rx_rd → first 4 words are retained in order, 5th is dropped, rx_overrun=1 and stays set until rst.
- Framing error: drive a frame with stop bit=0 → rx_frame_err pulses for 1 cycle and rx_empty stays 1. Drive a 3-cycle low glitch → no frame is started.
- Reset mid-frame: assert rst during the 4th TX data bit → uart_tx=1 immediately and tx_busy=0. The next write after reset transmits a clean frame.
- DATA_BITS=7 with UART_PARITY_EN: send 0x55 → parity bit on the line =0. An injected wrong parity bit → rx_frame_err pulse and no FIFO push.
